// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard receiver definitions: scan codes, event entry layout,
// frame FSM encoding and the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;

  localparam int EVT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a write into a full FIFO is dropped unless a
// pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_s, full_s, push_s, pop_s;

  always_comb begin
    empty_s = (count_q == '0);
    full_s  = (count_q == CW'(DEPTH));
    pop_s   = rd_en_i & ~empty_s;
    push_s  = wr_en_i & (~full_s | pop_s);
    drop_o  = wr_en_i & full_s & ~pop_s;
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rd_valid_o = ~empty_s;
  assign rd_data_o  = empty_s ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronise and de-glitch the bus, deframe bytes,
// fold E0/F0 prefixes into flags and queue key events in a FIFO.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [7:0]                    rd_code,
  output logic                          rd_ext,
  output logic                          rd_break,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d, filt_prev_q, fall_s;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  ps2_state_e      state_q, state_d;
  logic [9:0]      sh_q, sh_d;
  logic [3:0]      bit_q, bit_d;
  logic [TW-1:0]   to_q, to_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic            perr_s, ferr_s, push_s, drop_s;
  logic            perr_q, ferr_q, ovf_q;
  ps2_evt_t        evt_s, head_s;
  logic [EVT_W-1:0] head_bits_s;

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q == filt_q) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d    = clk_s2_q;
      flt_cnt_d = '0;
    end else begin
      flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall_s = filt_prev_q & ~filt_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    to_d    = to_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    perr_s  = 1'b0;
    ferr_s  = 1'b0;
    push_s  = 1'b0;
    evt_s   = {ext_q, brk_q, sh_q[7:0]};
    case (state_q)
      ST_IDLE: begin
        if (fall_s && !dat_s2_q) begin
          state_d = ST_SHIFT;
          sh_d    = '0;
          bit_d   = '0;
          to_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (fall_s) begin
          sh_d = {dat_s2_q, sh_q[9:1]};
          to_d = '0;
          if (bit_q == 4'd9) begin
            state_d = ST_CHECK;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = ST_IDLE;
          ferr_s  = 1'b1;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          to_d    = '0;
          bit_d   = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_CHECK: begin
        // sh_q holds {stop, parity, data[7:0]} after ten LSB-first shifts.
        state_d = ST_IDLE;
        if (!sh_q[9]) begin
          ferr_s = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (!odd_parity_ok(sh_q[7:0], sh_q[8])) begin
          perr_s = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (sh_q[7:0] == SC_E0) begin
          ext_d = 1'b1;
        end else if (sh_q[7:0] == SC_F0) begin
          brk_d = 1'b1;
        end else begin
          push_s = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus idles high, so synchronisers and filter reset to 1.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      bit_q       <= '0;
      to_q        <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_dat;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      to_q        <= to_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      perr_q      <= perr_s;
      ferr_q      <= ferr_s;
      ovf_q       <= ovf_q | drop_s;
    end
  end

  sync_fifo #(
    .WIDTH(EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .wr_en_i    (push_s),
    .wr_data_i  (evt_s),
    .rd_en_i    (rd_en),
    .rd_valid_o (rd_valid),
    .rd_data_o  (head_bits_s),
    .count_o    (count),
    .drop_o     (drop_s)
  );

  assign head_s     = head_bits_s;
  assign rd_code    = head_s.code;
  assign rd_ext     = head_s.ext;
  assign rd_break   = head_s.brk;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: a byte-level model (prefix rules, event queue,
// sticky overflow) is checked against the DUT every cycle, plus literal checks.
module tb_ps2_key_rx;

  localparam int FLEN  = 4;
  localparam int DEPTH = 4;
  localparam int TO    = 100;
  localparam int HALF  = 16;
  // 2 synchroniser stages + FILTER_LEN samples to the fall tick, then +2 to rd_valid.
  localparam int LAT   = 2 + FLEN + 2;

  logic CLOCK_50 = 1'b0;
  logic reset, ps2_clk, ps2_dat, rd_en;
  logic rd_valid, rd_ext, rd_break, parity_err, frame_err, overflow;
  logic [7:0] rd_code;
  logic [$clog2(DEPTH):0] count;

  int checks = 0, errors = 0, cyc = 0, c0_last = 0, last_rise = 0;
  int n_perr = 0, n_ferr = 0, p0 = 0, f0 = 0;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] code;
    logic       par;
    logic       stop;
  } act_t;

  act_t       pend[$];
  logic [9:0] mq[$];
  logic m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
  logic exp_perr = 1'b0, exp_ferr = 1'b0, prev_valid = 1'b0;
  logic [7:0] exp_codes [4];

  ps2_key_rx #(.FILTER_LEN(FLEN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_code    (rd_code),
    .rd_ext     (rd_ext),
    .rd_break   (rd_break),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Byte outcome from the protocol rules: stop, then parity, then prefix decode.
  task automatic apply(input act_t a);
    if (a.kind == 1 || !a.stop) begin
      exp_ferr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else if ((^{a.code, a.par}) == 1'b0) begin
      exp_perr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (a.code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (a.code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, a.code});
      else m_ovf = 1'b1;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge CLOCK_50);
    cyc++;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    if (reset) begin
      mq.delete(); pend.delete();
      m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    end else begin
      if (rd_en && mq.size() > 0) mq.delete(0);
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        apply(pend[0]);
        pend.delete(0);
      end
    end
  end

  initial forever begin
    @(negedge CLOCK_50);
    if (cyc > 0) begin
      chk("valid", 32'(rd_valid), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      if (mq.size() != 0) begin
        chk("code", 32'(rd_code), 32'(mq[0][7:0]));
        chk("ext", 32'(rd_ext), 32'(mq[0][9]));
        chk("brk", 32'(rd_break), 32'(mq[0][8]));
      end
      chk("parity_err", 32'(parity_err), 32'(exp_perr));
      chk("frame_err", 32'(frame_err), 32'(exp_ferr));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (parity_err) n_perr++;
      if (frame_err) n_ferr++;
      if (rd_valid && !prev_valid) last_rise = cyc;
      prev_valid = rd_valid;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pop_one();
    @(negedge CLOCK_50);
    rd_en = 1'b1;
    @(negedge CLOCK_50);
    rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input int pop_off, input int glitch_bit);
    logic [10:0] bits;
    act_t a;
    bits = {stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(6);
        ps2_clk = 1'b0;
        wait_cyc(FLEN - 1);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 6 - (FLEN - 1));
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        c0_last = cyc;
        a.due = cyc + LAT; a.kind = 0; a.code = b; a.par = bits[9]; a.stop = stop;
        pend.push_back(a);
      end
      for (int k = 1; k <= HALF; k++) begin
        @(negedge CLOCK_50);
        rd_en = (i == 10 && pop_off > 0 && cyc == c0_last + pop_off);
      end
      rd_en = 1'b0;
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    act_t a;
    logic [7:0] pb;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_en = 1'b0;
    exp_codes[0] = 8'h1E; exp_codes[1] = 8'h26; exp_codes[2] = 8'h25; exp_codes[3] = 8'h2E;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(4);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_code", 32'(rd_code), 32'd0);

    // Plain make code and its latency from the stop-bit edge.
    send_frame(8'h74, 1'b0, 1'b1, 0, -1);
    chk("lat_74", 32'(last_rise - c0_last), 32'd8);
    chk("code_74", 32'(rd_code), 32'h74);
    chk("ext_74", 32'(rd_ext), 32'd0);
    chk("count_74", 32'(count), 32'd1);
    pop_one();
    chk("count_pop", 32'(count), 32'd0);

    // Extended break sequence collapses to one entry.
    send_frame(8'hE0, 1'b0, 1'b1, 0, -1);
    send_frame(8'hF0, 1'b0, 1'b1, 0, -1);
    send_frame(8'h75, 1'b0, 1'b1, 0, -1);
    chk("count_75", 32'(count), 32'd1);
    chk("code_75", 32'(rd_code), 32'h75);
    chk("ext_75", 32'(rd_ext), 32'd1);
    chk("brk_75", 32'(rd_break), 32'd1);
    pop_one();

    // E0, bad-parity byte, then good 72: error clears the pending E0.
    p0 = n_perr;
    send_frame(8'hE0, 1'b0, 1'b1, 0, -1);
    send_frame(8'h6B, 1'b1, 1'b1, 0, -1);
    send_frame(8'h72, 1'b0, 1'b1, 0, -1);
    chk("perr_pulses", 32'(n_perr - p0), 32'd1);
    chk("code_72", 32'(rd_code), 32'h72);
    chk("ext_72", 32'(rd_ext), 32'd0);
    chk("count_72", 32'(count), 32'd1);
    pop_one();

    // Start bit then a stalled clock.
    f0 = n_ferr;
    ps2_dat = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    a.due = cyc + LAT - 1 + TO; a.kind = 1; a.code = 8'h00; a.par = 1'b0; a.stop = 1'b1;
    pend.push_back(a);
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(TO + 40);
    chk("timeout_pulses", 32'(n_ferr - f0), 32'd1);
    send_frame(8'h6B, 1'b0, 1'b1, 0, -1);
    chk("code_after_to", 32'(rd_code), 32'h6B);
    pop_one();

    // Bad stop bit, then E1 which is an ordinary code.
    f0 = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b0, 0, -1);
    chk("stop_pulses", 32'(n_ferr - f0), 32'd1);
    send_frame(8'hE1, 1'b0, 1'b1, 0, -1);
    chk("code_E1", 32'(rd_code), 32'hE1);
    chk("ext_E1", 32'(rd_ext), 32'd0);
    pop_one();

    // Short clock glitches: idle with data low, and mid-frame.
    f0 = n_ferr;
    ps2_dat = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b0;
    wait_cyc(FLEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(2);
    ps2_dat = 1'b1;
    wait_cyc(TO + LAT + 20);
    chk("glitch_idle", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h6B, 1'b0, 1'b1, 0, 5);
    chk("glitch_code", 32'(rd_code), 32'h6B);
    chk("glitch_count", 32'(count), 32'd1);
    pop_one();

    // Fill, push+pop while full, then a dropped push.
    send_frame(8'h16, 1'b0, 1'b1, 0, -1);
    send_frame(8'h1E, 1'b0, 1'b1, 0, -1);
    send_frame(8'h26, 1'b0, 1'b1, 0, -1);
    send_frame(8'h25, 1'b0, 1'b1, 0, -1);
    chk("full_count", 32'(count), 32'd4);
    send_frame(8'h2E, 1'b0, 1'b1, 7, -1);
    chk("pushpop_count", 32'(count), 32'd4);
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    send_frame(8'h36, 1'b0, 1'b1, 0, -1);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("readback", 32'(rd_code), 32'(exp_codes[i]));
      pop_one();
    end
    chk("drained", 32'(rd_valid), 32'd0);

    // Push with a simultaneous pop while empty.
    send_frame(8'h3D, 1'b0, 1'b1, 7, -1);
    chk("empty_pushpop", 32'(count), 32'd1);
    chk("empty_pushpop_code", 32'(rd_code), 32'h3D);

    // Reset in the middle of a frame.
    p0 = n_perr; f0 = n_ferr;
    pb = 8'h74;
    for (int i = 0; i < 5; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : pb[i - 1];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    ps2_dat = 1'b1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_ovf", 32'(overflow), 32'd0);
    wait_cyc(TO + 20);
    chk("rst_mid_errs", 32'(n_perr - p0 + n_ferr - f0), 32'd0);
    send_frame(8'h74, 1'b0, 1'b1, 0, -1);
    chk("post_rst_code", 32'(rd_code), 32'h74);
    chk("post_rst_count", 32'(count), 32'd1);

    wait_cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
